// File: rtl/cla_nl_arbiter.sv
// Round-robin front end sharing one nonlinear carry-term generator between NREQ
// requesters; two pipeline stages recombine the terms into a modulo-16 sum.

module gen_nonlinear_part (
  input  logic [3:0]  i_a,
  input  logic [3:0]  i_b,
  input  logic        i_cin,
  output logic [24:0] o_n
);
  logic w_unused_msb;
  assign w_unused_msb = i_a[3] ^ i_b[3];

  // Products of generate/propagate factors expanded to single AND terms.
  always_comb begin
    o_n     = '0;
    o_n[0]  = i_a[0] & i_b[0];
    o_n[1]  = i_a[0] & i_cin;
    o_n[2]  = i_b[0] & i_cin;
    o_n[3]  = i_a[1] & i_b[1];
    o_n[4]  = i_a[1] & i_a[0] & i_b[0];
    o_n[5]  = i_a[1] & i_a[0] & i_cin;
    o_n[6]  = i_a[1] & i_b[0] & i_cin;
    o_n[7]  = i_b[1] & i_a[0] & i_b[0];
    o_n[8]  = i_b[1] & i_a[0] & i_cin;
    o_n[9]  = i_b[1] & i_b[0] & i_cin;
    o_n[10] = i_a[2] & i_b[2];
    o_n[11] = i_a[2] & i_a[1] & i_b[1];
    o_n[12] = i_a[2] & i_a[1] & i_a[0] & i_b[0];
    o_n[13] = i_a[2] & i_a[1] & i_a[0] & i_cin;
    o_n[14] = i_a[2] & i_a[1] & i_b[0] & i_cin;
    o_n[15] = i_a[2] & i_b[1] & i_a[0] & i_b[0];
    o_n[16] = i_a[2] & i_b[1] & i_a[0] & i_cin;
    o_n[17] = i_a[2] & i_b[1] & i_b[0] & i_cin;
    o_n[18] = i_b[2] & i_a[1] & i_b[1];
    o_n[19] = i_b[2] & i_a[1] & i_a[0] & i_b[0];
    o_n[20] = i_b[2] & i_a[1] & i_a[0] & i_cin;
    o_n[21] = i_b[2] & i_a[1] & i_b[0] & i_cin;
    o_n[22] = i_b[2] & i_b[1] & i_a[0] & i_b[0];
    o_n[23] = i_b[2] & i_b[1] & i_a[0] & i_cin;
    o_n[24] = i_b[2] & i_b[1] & i_b[0] & i_cin;
  end
endmodule

// Handshake: a requester transfers when req_valid[i] & req_ready[i] at a rising
// edge; a result leaves when out_valid & out_ready; valid holds until accepted.
module cla_nl_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_sum,
  output logic [1:0]          out_id,
  output logic [1:0]          dbg_ptr
);
  logic        r_v1, r_v2;
  logic [3:0]  r_a1, r_b1, r_x2;
  logic [1:0]  r_id1, r_id2, r_ptr;
  logic [24:0] r_n2;
  logic [24:0] w_n;
  logic        w_s1_load, w_s2_load, w_found, w_xfer;
  logic [1:0]  w_gnt_idx, w_ptr_next;
  logic [3:0]  w_sel_a, w_sel_b;
  logic        w_c1, w_c2, w_c3;
  logic        w_unused_n;

  assign w_s2_load = ~r_v2 | out_ready;
  assign w_s1_load = ~r_v1 | w_s2_load;

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] && ((int'(r_ptr) + k) % NREQ) == i) begin
          w_found   = 1'b1;
          w_gnt_idx = 2'(i);
        end
      end
    end
  end

  // Grant is suppressed while reset is asserted so no accept can leak out.
  assign w_xfer = w_found & w_s1_load & ~rst;
  assign w_ptr_next = (w_gnt_idx == 2'(NREQ - 1)) ? 2'd0 : w_gnt_idx + 2'd1;

  always_comb begin
    req_ready = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_xfer && (w_gnt_idx == 2'(i));
      if (w_gnt_idx == 2'(i)) begin
        w_sel_a = req_a[4*i +: 4];
        w_sel_b = req_b[4*i +: 4];
      end
    end
  end

  gen_nonlinear_part u_nl (
    .i_a   (r_a1),
    .i_b   (r_b1),
    .i_cin (1'b0),
    .o_n   (w_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_id1 <= '0;
      r_x2  <= '0;
      r_n2  <= '0;
      r_id2 <= '0;
      r_ptr <= '0;
    end else begin
      if (w_s2_load) begin
        r_v2  <= r_v1;
        r_x2  <= r_a1 ^ r_b1;
        r_n2  <= w_n;
        r_id2 <= r_id1;
      end
      if (w_s1_load) begin
        r_v1 <= w_xfer;
        if (w_xfer) begin
          r_a1  <= w_sel_a;
          r_b1  <= w_sel_b;
          r_id1 <= w_gnt_idx;
        end
      end
      if (w_xfer) r_ptr <= w_ptr_next;
    end
  end

  assign w_c1 = r_n2[0];
  assign w_c2 = r_n2[3] ^ r_n2[4] ^ r_n2[7];
  assign w_c3 = r_n2[10] ^ r_n2[11] ^ r_n2[12] ^ r_n2[15] ^ r_n2[18] ^ r_n2[19] ^ r_n2[22];
  // Carry-in terms are constant zero and play no part in the sum.
  assign w_unused_n = ^{r_n2[24:23], r_n2[21:20], r_n2[17:16], r_n2[14:13],
                        r_n2[9:8], r_n2[6:5], r_n2[2:1]};

  assign out_sum   = r_x2 ^ {w_c3, w_c2, w_c1, 1'b0};
  assign out_valid = r_v2;
  assign out_id    = r_id2;
  assign dbg_ptr   = r_ptr;
endmodule

// File: tb/tb_cla_nl_arbiter.sv
// Bench for cla_nl_arbiter with four requesters: table vectors, rotation,
// stall, reset and pointer sequences, plus a full operand sweep.
module tb_cla_nl_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic              out_valid, out_ready;
  logic [3:0]        out_sum;
  logic [1:0]        out_id, dbg_ptr;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [5:0]      exp_q[$];
  int              grant_log[$];
  logic [NREQ-1:0] xfer_mask;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  cla_nl_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id),
    .dbg_ptr   (dbg_ptr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; advances one cycle.
  task automatic step();
    logic [5:0] e;
    #1;
    check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    xfer_mask = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_mask[i]) begin
        exp_q.push_back({2'(i), 4'((int'(req_a[4*i +: 4]) + int'(req_b[4*i +: 4])) % 16)});
        grant_log.push_back(i);
      end
    end
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: id=%0d sum=%0h with nothing expected", out_id, out_sum);
      end else begin
        e = exp_q.pop_front();
        check("out_id", 32'(out_id), 32'(e[5:4]));
        check("out_sum", 32'(out_sum), 32'(e[3:0]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int id, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[4*id +: 4] = a;
    req_b[4*id +: 4] = b;
    xfer_mask = '0;
    while (!xfer_mask[id] && n < 100) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    if (!xfer_mask[id]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: requester %0d not accepted in 100 cycles", id);
    end
    req_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{4'd5,  4'd6,  4'hB};
    tbl[1] = '{4'd7,  4'd9,  4'h0};
    tbl[2] = '{4'd15, 4'd15, 4'hE};
    tbl[3] = '{4'd3,  4'd1,  4'h4};
    tbl[4] = '{4'd8,  4'd8,  4'h0};
    tbl[5] = '{4'd10, 4'd3,  4'hD};

    rst = 1'b1;
    req_valid = 4'b0001;
    req_a = '0;
    req_b = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors through requester 0, checking the two-cycle latency.
    for (int t = 0; t < 6; t++) begin
      req_valid = 4'b0001;
      req_a[3:0] = tbl[t].a;
      req_b[3:0] = tbl[t].b;
      step();
      check("tbl_accept", 32'(xfer_mask), 32'h1);
      req_valid = '0;
      #1 check("tbl_lat_t1", 32'(out_valid), 32'd0);
      step();
      #1;
      check("tbl_lat_t2", 32'(out_valid), 32'd1);
      check("tbl_sum", 32'(out_sum), 32'(tbl[t].sum));
      check("tbl_id", 32'(out_id), 32'd0);
      step();
    end
    drain();

    // Pointer: grant to 3 wraps to 0, then a lone requester 1 moves it to 2.
    req_valid = 4'b1000;
    req_a[15:12] = 4'd9;
    req_b[15:12] = 4'd4;
    step();
    check("p3_accept", 32'(xfer_mask), 32'h8);
    #1 check("p3_ptr", 32'(dbg_ptr), 32'd0);
    req_valid = 4'b0010;
    req_a[7:4] = 4'd2;
    req_b[7:4] = 4'd12;
    #1 check("p1_ready_same_cycle", 32'(req_ready), 32'h2);
    step();
    #1 check("p1_ptr", 32'(dbg_ptr), 32'd2);
    drain();

    // All four valid: strict rotation from the current pointer, one result per cycle.
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(3 * i + 5);
      req_b[4*i +: 4] = 4'(4 * i + 2);
    end
    req_valid = '1;
    out_ready = 1'b1;
    grant_log.delete();
    pops = 0;
    for (int c = 0; c < 8; c++) step();
    check("rot_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("rot_order", 32'(grant_log[k]), 32'((k + 2) % NREQ));
    check("rot_throughput", 32'(pops), 32'd6);
    drain();

    // Stall with requests pending: exactly two results held.
    out_ready = 1'b0;
    req_valid = '1;
    grant_log.delete();
    for (int c = 0; c < 5; c++) step();
    check("stall_accepts", 32'(grant_log.size()), 32'd2);
    check("stall_buffered", 32'(exp_q.size()), 32'd2);
    #1;
    check("stall_ready", 32'(req_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    pops = 0;
    step();
    check("release_accept", 32'(xfer_mask != 0), 32'd1);
    check("release_pop", 32'(pops), 32'd1);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) step();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_ptr", 32'(dbg_ptr), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0101;
    out_ready = 1'b1;
    #1 check("postrst_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("postrst_inflight", 32'(exp_q.size()), 32'd1);
    drain();

    // Exhaustive sweep through requester 1 under random back-pressure.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        send(1, 4'(a), 4'(b));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
